timer_array: RTL

Multi-channel, parametrised interval timer for the system peripheral bus, behind the bridge alongside LED, switch, digital-tube and UART devices. Provides `NUM_CH` independent down-counters with one-shot, auto-reload and square-wave modes, per-channel sticky pending flags with write-1-to-clear and per-channel interrupt masks. The mask-qualified pendings are OR-reduced onto a single `IRQ` line that drives one `HWInt` bit of the cpu.

---
 rtl/timer_array.sv | 135 +++++++++++++
 1 files changed

// File: rtl/timer_array.sv
// timer_array: NUM_CH bus-mapped down-counters (one-shot, auto-reload,
// square-wave) with sticky W1C pendings and a masked, OR-reduced IRQ.
module timer_array #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [4:0]        PrAddr,
    input  logic              Wr_en,
    input  logic [31:0]       Data_in,
    output logic [31:0]       Data_out,
    output logic              IRQ,
    output logic [NUM_CH-1:0] irq_vec,
    output logic [NUM_CH-1:0] wave_out
);
    typedef enum logic [1:0] {IDLE, LOAD, CNT} state_t;

    logic [2:0] ch;
    logic [1:0] rsel;
    logic [NUM_CH-1:0][31:0] rdat;

    assign ch   = PrAddr[4:2];
    assign rsel = PrAddr[1:0];

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        state_t state, state_nx;
        logic en, im;
        logic [1:0] mode;
        logic [CNT_W-1:0] preset, count;
        logic pend, wave;
        logic hit, wr_ctrl, wr_pre, wr_sts;
        logic kill, restart, evt, load, dec;
        logic oneshot, square;
        logic [31:0] rd;

        assign hit     = Wr_en && (ch == 3'(i));
        assign wr_ctrl = hit && (rsel == 2'd0);
        assign wr_pre  = hit && (rsel == 2'd1);
        assign wr_sts  = hit && (rsel == 2'd3);
        assign oneshot = (mode[1] == mode[0]);
        assign square  = (mode == 2'b10);
        assign kill    = wr_ctrl && !Data_in[0];
        assign restart = wr_pre && en;

        // Register writes take priority over a coincident count event.
        always_comb begin
            state_nx = state;
            evt      = 1'b0;
            unique case (state)
                IDLE: begin
                    if ((wr_ctrl && Data_in[0]) || restart)
                        state_nx = LOAD;
                end
                LOAD: state_nx = restart ? LOAD : CNT;
                CNT: begin
                    if (restart) begin
                        state_nx = LOAD;
                    end else if (count <= CNT_W'(1)) begin
                        evt = 1'b1;
                        if (oneshot)
                            state_nx = IDLE;
                    end
                end
                default: state_nx = IDLE;
            endcase
            if (kill) begin
                state_nx = IDLE;
                evt      = 1'b0;
            end
        end

        assign load = (state == LOAD) && (state_nx == CNT);
        assign dec  = (state == CNT) && (state_nx == CNT) && !evt;

        always_ff @(posedge clk) begin
            if (reset) begin
                state  <= IDLE;
                en     <= 1'b0;
                mode   <= 2'b00;
                im     <= 1'b0;
                preset <= '0;
                count  <= '0;
                pend   <= 1'b0;
                wave   <= 1'b0;
            end else begin
                state <= state_nx;
                if (wr_ctrl) begin
                    en   <= Data_in[0];
                    mode <= Data_in[2:1];
                    im   <= Data_in[3];
                end
                if (wr_pre)
                    preset <= Data_in[CNT_W-1:0];
                if (load)
                    count <= preset;
                else if (evt)
                    count <= oneshot ? '0 : preset;
                else if (dec)
                    count <= count - CNT_W'(1);
                // Set beats a same-cycle write-1-to-clear.
                if (evt)
                    pend <= 1'b1;
                else if (wr_sts && Data_in[0])
                    pend <= 1'b0;
                if (evt && square)
                    wave <= ~wave;
                if (evt && oneshot)
                    en <= 1'b0;
            end
        end

        always_comb begin
            unique case (rsel)
                2'd0:    rd = {28'd0, im, mode, en};
                2'd1:    rd = 32'(preset);
                2'd2:    rd = 32'(count);
                default: rd = {31'd0, pend};
            endcase
        end

        assign rdat[i]     = rd;
        assign irq_vec[i]  = pend & im;
        assign wave_out[i] = wave;
    end

    always_comb begin
        Data_out = '0;
        for (int i = 0; i < NUM_CH; i++)
            if (ch == 3'(i))
                Data_out = rdat[i];
    end

    assign IRQ = |irq_vec;
endmodule
